// File: rtl/sccb_pkg.sv
// Shared constants and types for the SCCB camera configuration master.
package sccb_pkg;
    localparam logic [15:0] SCCB_ENTRY_DELAY = 16'hFFF0;
    localparam logic [15:0] SCCB_ENTRY_END   = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_START,
        ST_BITS,
        ST_STOP,
        ST_GAP,
        ST_DELAY,
        ST_DONE
    } sccb_state_t;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] val;
    } sccb_entry_t;
endpackage

// File: rtl/ov7670_cfg_rom.sv
// OV7670 register table: combinational index to {reg, val} lookup.
// USE_OVR substitutes a 16-entry table for bring-up of short sequences.
module ov7670_cfg_rom
    import sccb_pkg::*;
#(
    parameter int             ROM_AW  = 8,
    parameter bit             USE_OVR = 1'b0,
    parameter logic [255:0]   OVR_TBL = '1
) (
    input  logic [ROM_AW-1:0] idx,
    output sccb_entry_t       entry
);
    logic [15:0] rom_word;

    always_comb begin
        rom_word = SCCB_ENTRY_END;
        if (USE_OVR) begin
            if (int'(idx) < 16)
                rom_word = OVR_TBL[int'(idx)*16 +: 16];
        end else begin
            case (int'(idx))
                0:  rom_word = 16'h1280;          // COM7 soft reset
                1:  rom_word = SCCB_ENTRY_DELAY;  // let the sensor settle
                2:  rom_word = 16'h1200;          // COM7: VGA, YUV
                3:  rom_word = 16'h1101;          // CLKRC
                4:  rom_word = 16'h0C00;
                5:  rom_word = 16'h3E00;
                6:  rom_word = 16'h3A04;          // TSLB
                7:  rom_word = 16'h40C0;          // COM15 full range
                8:  rom_word = 16'h8C00;
                9:  rom_word = 16'h1711;          // HSTART
                10: rom_word = 16'h1861;          // HSTOP
                11: rom_word = 16'h32A4;          // HREF
                12: rom_word = 16'h1903;          // VSTART
                13: rom_word = 16'h1A7B;          // VSTOP
                14: rom_word = 16'h030A;          // VREF
                15: rom_word = 16'h0F41;
                16: rom_word = 16'h1E00;          // MVFP
                17: rom_word = 16'h3DC0;          // COM13 gamma, UV auto
                18: rom_word = 16'h13E7;          // COM8 AGC/AWB/AEC
                default: rom_word = SCCB_ENTRY_END;
            endcase
        end
    end

    assign entry = sccb_entry_t'(rom_word);
endmodule

// File: rtl/sccb_config.sv
// SCCB 3-phase write master: walks the OV7670 table on start, one write per entry.
// Bus outputs decode directly from state so reset forces an idle bus in the same cycle.
module sccb_config
    import sccb_pkg::*;
#(
    parameter int           QDIV         = 125,
    parameter logic [7:0]   DEV_ADDR     = 8'h42,
    parameter int           DELAY_CYCLES = 50000,
    parameter int           ROM_AW       = 8,
    parameter bit           USE_ROM_OVR  = 1'b0,
    parameter logic [255:0] ROM_OVR      = '1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              siod_in,
    output logic              sioc,
    output logic              siod_out,
    output logic              siod_oe,
    output logic              busy,
    output logic              done,
    output logic              ack_err,
    output logic [ROM_AW-1:0] idx
);
    localparam int QW = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam int DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

    sccb_state_t   state;
    logic [QW-1:0] qcnt;
    logic [1:0]    quarter;
    logic [3:0]    bitn;
    logic [1:0]    byten;
    logic [23:0]   shreg;
    logic [DW-1:0] dcnt;
    logic          tick;
    logic          qrun;
    sccb_entry_t   entry;

    ov7670_cfg_rom #(
        .ROM_AW  (ROM_AW),
        .USE_OVR (USE_ROM_OVR),
        .OVR_TBL (ROM_OVR)
    ) u_rom (
        .idx   (idx),
        .entry (entry)
    );

    assign qrun = (state == ST_START) || (state == ST_BITS) ||
                  (state == ST_STOP)  || (state == ST_GAP);
    assign tick = qrun && (qcnt == QW'(QDIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            qcnt <= '0;
        else if (!qrun || tick)
            qcnt <= '0;
        else
            qcnt <= qcnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            quarter <= '0;
            bitn    <= '0;
            byten   <= '0;
            shreg   <= '0;
            dcnt    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ack_err <= 1'b0;
            idx     <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        ack_err <= 1'b0;
                        idx     <= '0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        state   <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    quarter <= '0;
                    bitn    <= '0;
                    byten   <= '0;
                    dcnt    <= '0;
                    if (entry == SCCB_ENTRY_END) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else if (entry == SCCB_ENTRY_DELAY) begin
                        state <= ST_DELAY;
                    end else begin
                        shreg <= {DEV_ADDR, entry};
                        state <= ST_START;
                    end
                end
                ST_START: if (tick) begin
                    quarter <= quarter + 2'd1;
                    if (quarter == 2'd3) state <= ST_BITS;
                end
                ST_BITS: if (tick) begin
                    quarter <= quarter + 2'd1;
                    // Ninth bit is don't-care in SCCB: flag a NACK but keep going
                    if (bitn == 4'd8 && quarter == 2'd2 && siod_in)
                        ack_err <= 1'b1;
                    if (quarter == 2'd3) begin
                        if (bitn == 4'd8) begin
                            bitn  <= '0;
                            byten <= byten + 2'd1;
                            if (byten == 2'd2) state <= ST_STOP;
                        end else begin
                            bitn  <= bitn + 4'd1;
                            shreg <= {shreg[22:0], 1'b0};
                        end
                    end
                end
                ST_STOP: if (tick) begin
                    quarter <= quarter + 2'd1;
                    if (quarter == 2'd3) state <= ST_GAP;
                end
                ST_GAP: if (tick) begin
                    quarter <= quarter + 2'd1;
                    if (quarter == 2'd3) begin
                        idx   <= idx + 1'b1;
                        state <= ST_FETCH;
                    end
                end
                ST_DELAY: begin
                    if (dcnt == DW'(DELAY_CYCLES - 1)) begin
                        dcnt  <= '0;
                        idx   <= idx + 1'b1;
                        state <= ST_FETCH;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        sioc     = 1'b1;
        siod_out = 1'b1;
        siod_oe  = 1'b1;
        case (state)
            ST_START: begin
                sioc     = (quarter != 2'd3);
                siod_out = (quarter == 2'd0);
            end
            ST_BITS: begin
                sioc = (quarter == 2'd1) || (quarter == 2'd2);
                if (bitn == 4'd8) siod_oe  = 1'b0;
                else              siod_out = shreg[23];
            end
            ST_STOP: begin
                sioc     = (quarter != 2'd0);
                siod_out = quarter[1];
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_sccb_config.sv
// Bench for sccb_config: cycle-level waveform model built from the table, vectors plus random runs.
module tb_sccb_config;
    localparam int QDIV = 2;
    localparam int DLY  = 10;
    localparam logic [255:0] TBL = {{12{16'hFFFF}}, 16'hFFFF, 16'h1104, 16'hFFF0, 16'h1280};

    logic clk = 1'b0;
    logic rst_n, start, siod_in;
    logic sioc, siod_out, siod_oe, busy, done, ack_err;
    logic [7:0] idx;

    sccb_config #(
        .QDIV(QDIV), .DEV_ADDR(8'h42), .DELAY_CYCLES(DLY), .ROM_AW(8),
        .USE_ROM_OVR(1'b1), .ROM_OVR(TBL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .siod_in(siod_in),
        .sioc(sioc), .siod_out(siod_out), .siod_oe(siod_oe),
        .busy(busy), .done(done), .ack_err(ack_err), .idx(idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sioc, siod, oe, ack;
        logic [7:0] idx;
        int         ackb;
    } exp_t;

    typedef struct {
        logic [5:0] mask;
        int         dup;
        logic       exp_ack;
    } vec_t;

    exp_t        expq[$];
    logic [15:0] mtbl[4];
    logic        m_sticky;
    int          nchk = 0;
    int          nerr = 0;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic put(input logic c, input logic d, input logic oe, input int ib, input int ab, input int n);
        exp_t e;
        e.sioc = c; e.siod = d; e.oe = oe; e.ack = m_sticky; e.idx = 8'(ib); e.ackb = ab;
        for (int i = 0; i < n; i++) expq.push_back(e);
    endtask

    // Expected pin waveform, one element per clk cycle from the FETCH after start
    task automatic build(input logic [5:0] mask);
        int nb;
        logic [23:0] bytes;
        logic d;
        nb = 0;
        m_sticky = 1'b0;
        expq.delete();
        for (int i = 0; i < 4; i++) begin
            put(1, 1, 1, i, -1, 1);
            if (mtbl[i] == 16'hFFFF) break;
            if (mtbl[i] == 16'hFFF0) begin
                put(1, 1, 1, i, -1, DLY);
            end else begin
                bytes = {8'h42, mtbl[i]};
                put(1, 1, 1, i, -1, QDIV); put(1, 0, 1, i, -1, QDIV);
                put(1, 0, 1, i, -1, QDIV); put(0, 0, 1, i, -1, QDIV);
                for (int b = 0; b < 3; b++) begin
                    for (int k = 0; k < 8; k++) begin
                        d = bytes[23 - 8*b - k];
                        put(0, d, 1, i, -1, QDIV); put(1, d, 1, i, -1, QDIV);
                        put(1, d, 1, i, -1, QDIV); put(0, d, 1, i, -1, QDIV);
                    end
                    put(0, 1, 0, i, nb, QDIV); put(1, 1, 0, i, nb, QDIV);
                    put(1, 1, 0, i, nb, QDIV);
                    if (mask[nb]) m_sticky = 1'b1;
                    put(0, 1, 0, i, nb, QDIV);
                    nb++;
                end
                put(0, 0, 1, i, -1, QDIV); put(1, 0, 1, i, -1, QDIV);
                put(1, 1, 1, i, -1, QDIV); put(1, 1, 1, i, -1, QDIV);
                put(1, 1, 1, i, -1, 4*QDIV);
            end
        end
    endtask

    task automatic run(input logic [5:0] mask, input int dup, input logic exp_ack, input string tag);
        int nmis, first, nbusy, hichg;
        logic psioc, pline, line, mis;
        string fdet;
        build(mask);
        nmis = 0; first = -1; nbusy = 0; hichg = 0; psioc = 1; pline = 1; fdet = "";
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < expq.size(); k++) begin
            if (k > 0) @(negedge clk);
            start   = (k == dup);
            siod_in = (expq[k].ackb >= 0) ? mask[expq[k].ackb] : 1'b0;
            #1;
            mis = (sioc !== expq[k].sioc) || (siod_oe !== expq[k].oe) ||
                  (expq[k].oe && siod_out !== expq[k].siod) || (busy !== 1'b1) ||
                  (done !== 1'b0) || (ack_err !== expq[k].ack) || (idx !== expq[k].idx);
            if (mis) begin
                if (nmis == 0)
                    $sformat(fdet, "cyc %0d got c%b d%b oe%b b%b dn%b a%b i%0d want c%b d%b oe%b a%b i%0d",
                             k, sioc, siod_out, siod_oe, busy, done, ack_err, idx,
                             expq[k].sioc, expq[k].siod, expq[k].oe, expq[k].ack, expq[k].idx);
                nmis++;
            end
            if (busy === 1'b1) nbusy++;
            line = siod_oe ? siod_out : siod_in;
            if (psioc && sioc && line !== pline) hichg++;
            psioc = sioc; pline = line;
        end
        nchk++;
        if (nmis != 0) begin
            nerr++;
            $display("FAIL %s wave: %0d bad cycles, first %s", tag, nmis, fdet);
        end
        chk({tag, " busy_cycles"}, nbusy, 4 + 2*120*QDIV + DLY);
        chk({tag, " sioc_high_siod_edges"}, hichg, 4);
        @(negedge clk); start = 1'b0; siod_in = 1'b0; #1;
        chk({tag, " done"}, done, 1);
        chk({tag, " busy_end"}, busy, 0);
        chk({tag, " idx_end"}, idx, 3);
        chk({tag, " ack_err"}, ack_err, exp_ack);
    endtask

    initial begin
        vec_t vt[5];
        logic [5:0] m;
        mtbl = '{16'h1280, 16'hFFF0, 16'h1104, 16'hFFFF};
        vt[0] = '{mask: 6'b000000, dup: -1,  exp_ack: 1'b0};
        vt[1] = '{mask: 6'b000010, dup: -1,  exp_ack: 1'b1};
        vt[2] = '{mask: 6'b000000, dup: 100, exp_ack: 1'b0};
        vt[3] = '{mask: 6'b100000, dup: 300, exp_ack: 1'b1};
        vt[4] = '{mask: 6'b000000, dup: 5,   exp_ack: 1'b0};

        rst_n = 1'b0; start = 1'b0; siod_in = 1'b0;
        #1;
        chk("rst sioc", sioc, 1);     chk("rst siod_out", siod_out, 1);
        chk("rst siod_oe", siod_oe, 1); chk("rst busy", busy, 0);
        chk("rst done", done, 0);     chk("rst ack_err", ack_err, 0);
        chk("rst idx", idx, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle done", done, 0);

        for (int v = 0; v < 5; v++) run(vt[v].mask, vt[v].dup, vt[v].exp_ack, $sformatf("vec%0d", v));

        for (int r = 0; r < 6; r++) begin
            m = 6'($urandom_range(0, 63));
            run(m, $urandom_range(0, 493), |m, $sformatf("rnd%0d", r));
        end

        // Abort in the second byte with a NACK already latched
        @(negedge clk); start = 1'b1; siod_in = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (90) @(negedge clk);
        #1;
        chk("pre_rst ack_err", ack_err, 1);
        chk("pre_rst busy", busy, 1);
        rst_n = 1'b0; #1;
        chk("abort sioc", sioc, 1);     chk("abort siod_out", siod_out, 1);
        chk("abort siod_oe", siod_oe, 1); chk("abort busy", busy, 0);
        chk("abort idx", idx, 0);       chk("abort ack_err", ack_err, 0);
        chk("abort done", done, 0);
        siod_in = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        run(6'b000000, -1, 1'b0, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/sccb_config.md
Name: sccb_config

Overview:
- SCCB (I2C-like) write master that programs the OV7670 camera registers over the sioc/siod pins.
- It is the outbound control path to the camera; camera_read is the inbound pixel receiver for the same sensor.
- On a start pulse it walks a register/value table and issues one 3-phase SCCB write per entry, with an optional delay entry (for example after a soft reset).
- It then signals done; the top level drives ARDUINO_IO[15] from sioc and ARDUINO_IO[14] from siod_out/siod_oe as a tristate.

Parameters:
- QDIV, 125, clk cycles per SCCB quarter-bit (50 MHz / (4×125) = 100 kHz SCL).
- DEV_ADDR, 8'h42, camera write address (byte 0 of every transaction).
- DELAY_CYCLES, 50000, wait length for a delay entry (1 ms at 50 MHz).
- ROM_AW, 8, table index width.

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to run the whole table
- siod_in  in  1  sampled SIOD pin level, externally synchronised
- sioc  out  1  SCCB clock
- siod_out  out  1  SIOD drive value
- siod_oe  out  1  1 = drive siod_out, 0 = release (high-Z)
- busy  out  1  high from the cycle after an accepted start until DONE is entered
- done  out  1  high in DONE, held until the next accepted start
- ack_err  out  1  sticky; set when a 9th-bit sample reads 1; cleared on an accepted start
- idx  out  ROM_AW  current table index (debug)

Behaviour:
- Reset values (async, rst_n=0):
  - sioc=1, siod_out=1, siod_oe=1; busy=0, done=0, ack_err=0, idx=0.
  - State is IDLE and the quarter counter is 0.
  - Reset mid-transaction aborts immediately to these values; no stop condition is generated.
- Quarter tick:
  - A counter counts 0..QDIV-1; tick pulses when it wraps.
  - Every bus state advances only on tick. The counter is held at 0 in IDLE, FETCH and DONE.
- Table entries:
  - 16 bits, {reg[15:8], val[7:0]}.
  - 16'hFFF0 = delay entry. 16'hFFFF = end marker.
  - Any other value is a register write.
- States:
  - IDLE: if start, clear ack_err, set idx=0, go to FETCH. start in any other state except DONE is ignored.
  - FETCH (1 cycle): look up entry[idx].
    - End marker → DONE.
    - Delay entry → DELAY.
    - Otherwise latch the shift bytes {DEV_ADDR, reg, val} and go to START.
  - START, 4 quarters:
    - q0: sioc=1, siod=1.
    - q1: siod=0.
    - q2: siod=0.
    - q3: sioc=0.
  - BITS: 3 bytes × 9 bits, MSB first; each bit is 4 quarters.
    - q0: sioc=0, set siod.
    - q1: sioc=1.
    - q2: sioc=1.
    - q3: sioc=0.
    - Bit 8 of each byte: siod_oe=0; sample siod_in at the end of q2; if 1, set ack_err.
    - A NACK does not abort the transfer (SCCB "don't care" bit).
  - STOP, 4 quarters:
    - q0: sioc=0, siod=0, oe=1.
    - q1: sioc=1.
    - q2: siod=1.
    - q3: hold.
  - GAP: 4 quarters of idle bus (sioc=1, siod=1), then idx+1 → FETCH.
  - DELAY: count DELAY_CYCLES clk cycles with the bus idle, then idx+1 → FETCH.
  - DONE: busy=0, done=1; a start re-enters as in IDLE.
- Timing:
  - One register write = 120 quarters = 120×QDIV cycles on the bus, plus 1 FETCH cycle.
  - idx wraps modulo 2^ROM_AW. If no end marker exists, the table is rerun indefinitely; this is a table error, not handled.
- SIOD changes only while sioc=0, except during start and stop.

Decomposition:
- Package sccb_pkg: SCCB_ENTRY_DELAY=16'hFFF0, SCCB_ENTRY_END=16'hFFFF, the state enum typedef, and the entry typedef (struct of reg/val bytes).
- Sub-module ov7670_cfg_rom: combinational idx → 16-bit entry.
  - Holds the OV7670 table: 12'h80 COM7 reset, delay, then the QVGA/VGA YUV settings, then END.
  - The bench replaces it with a short table.

Test Plan (QDIV=2, DELAY_CYCLES=10, siod_in tied 0 unless stated):
1. Table {16'h1280, END}, pulse start → SCCB decode shows start, bytes 0x42, 0x12, 0x80 and stop. busy high for 1+120×2 cycles plus the final FETCH, then done=1, ack_err=0.
2. Table {16'h1280, 16'hFFF0, 16'h1104, END} → two transactions separated by exactly 10 idle cycles with sioc=1, siod=1 after the GAP, then done.
3. siod_in=1 during the second byte's ack bit → ack_err=1 at the end of that q2 and sticky through done; the transaction still completes all 3 bytes. A new start clears ack_err.
4. Assert rst_n=0 during byte 1 → same cycle: sioc=1, siod_out=1, oe=1, busy=0, idx=0. After release, start runs the table from entry 0.
5. start pulsed while busy → ignored, byte stream unchanged. start while done=1 → the table reruns identically.
6. Protocol checker on all runs: siod never changes while sioc=1, except at start/stop edges; siod_oe=0 only in the 9th-bit window.
